dsc_stream_decoder: RTL and testbench
=====================================

# dsc_stream_decoder

Receive-side block for deterministic stochastic computing (DSC) datapaths: accepts a framed serial unary bitstream, such as the AND of cascaded SNG outputs, and converts each frame back to binary by counting ones. A completed count is handed to a downstream consumer through a one-entry valid/ready output register. Backpressure reaches the bitstream source through `bs_ready`. It sits at the output of DSC serial arithmetic units whose frame length is 2^(DATA_WIDTH·NUM_INPUTS) cycles.

## Interface
Parameters:
- `DATA_WIDTH`, 5, operand width of each upstream SNG.
- `NUM_INPUTS`, 2, number of cascaded operands; frame length `FRAME_LEN` = 2^(DATA_WIDTH·NUM_INPUTS).
- `WXIP1`, DATA_WIDTH·NUM_INPUTS+1 (derived), result width; holds counts 0..FRAME_LEN inclusive.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `bs_valid`  in  1  bitstream bit present this cycle.
- `bs_data`  in  1  bitstream bit value.
- `bs_sof`  in  1  qualifies the current valid bit as first bit of a frame.
- `bs_ready`  out  1  decoder accepts a bit this cycle.
- `res_valid`  out  1  `res_data` holds a completed count.
- `res_ready`  in  1  consumer takes the result.
- `res_data`  out  WXIP1  ones-count of the last completed frame.
- `err_drop`  out  1  1-cycle pulse: a valid bit arrived in IDLE without `sof` and was discarded.
- `err_abort`  out  1  1-cycle pulse: `sof` arrived mid-frame and the partial frame was discarded.

## Operation
- A bit is accepted when `bs_valid && bs_ready`.
- State machine:
  - IDLE: an accepted bit with `sof=1` loads `ones_cnt`←`bs_data` and `bit_cnt`←1, then goes to ACCUM. An accepted bit with `sof=0` is dropped and pulses `err_drop`.
  - ACCUM: on each accepted bit, `ones_cnt`+=`bs_data` and `bit_cnt`+=1.
    - When the accepted bit is bit FRAME_LEN (`bit_cnt` was FRAME_LEN−1), the frame completes. The final count, including this bit, goes to the output register if the register is free; the FSM then returns to IDLE. If the register is not free, the FSM goes to HOLD with the count retained.
    - An accepted bit with `sof=1` in ACCUM restarts the frame with this bit (`ones_cnt`←`bs_data`, `bit_cnt`←1) and pulses `err_abort`.
  - HOLD: `bs_ready`=0. When the output register frees, the count is transferred and the FSM goes to IDLE.
- Output register is "free" when `!res_valid || res_ready` (same-cycle drain and refill allowed).
- `bs_ready` = 1 in IDLE and ACCUM, 0 in HOLD.
- `bit_cnt` is DATA_WIDTH·NUM_INPUTS+1 bits wide. `ones_cnt` is WXIP1 bits and never wraps: the maximum is FRAME_LEN, reached with an all-ones frame.
- `res_data` is stable while `res_valid && !res_ready`.

## Timing
- Reset values: state IDLE, counters 0, `res_valid`=0, `res_data`=0, `err_drop`=0, `err_abort`=0. `bs_ready` = 1 while `rst` is high and after reset (IDLE).
- Latency: `res_valid` rises on the clock edge that accepts the last bit of a frame. It is observable the cycle after the last bit is presented.
- Throughput: back-to-back frames with no gap are sustained when `res_ready` is held at 1. The `sof` of frame n+1 may arrive on the cycle after the last bit of frame n.
- Gaps: `bs_valid`=0 cycles inside a frame do not advance `bit_cnt`.
- The HOLD→IDLE transfer takes one edge after `res_ready` is seen. `bs_ready` returns to 1 on the following cycle.
- Reset mid-operation: the partial frame and any held or output result are discarded. No error pulse is generated.

## Structure
- Shared DSC package: FSM state enum (IDLE, ACCUM, HOLD), and the `WXIP1` and `FRAME_LEN` derivation functions. These are also used by the SNG and multiplier blocks.
- One natural sub-module: `dsc_result_reg`, a one-entry valid/ready holding register, reusable by other DSC blocks.
- Counters stay inline.

## Test plan
All scenarios use `DATA_WIDTH`=2, `NUM_INPUTS`=2, so FRAME_LEN=16 and WXIP1=5.
- Frame of 16 bits, 5 ones, `res_ready`=1 → `res_data`=5, with `res_valid` for 1 cycle right after the last bit.
- All-ones frame → `res_data`=16 (no wrap). All-zeros frame → `res_data`=0.
- Two back-to-back frames (7 and 12 ones), `res_ready` low for 20 cycles after frame 1 →
  - `res_data`=7 held stable throughout;
  - `bs_ready`=0 after frame 2 completes;
  - on release, 7 is delivered, then 12 on the next transfer.
- Valid bits with `sof`=0 in IDLE → one `err_drop` pulse per bit, no result. A following proper frame counts correctly.
- `sof` at bit 9 of a frame → one `err_abort` pulse; the result reflects only the 16 bits starting at the new `sof`.
- Assert `rst` at bit 10 of a frame and while a result is pending → all outputs return to reset values. The next frame decodes correctly.

Source files
------------

// File: rtl/dsc_pkg.sv
// -----------------------------------------------------------------------------
// dsc_pkg
// Shared definitions for the deterministic stochastic computing (DSC) blocks:
// the decoder FSM state encoding and the helpers that derive frame length and
// result width from operand width and operand count.
// No ports (package).
// -----------------------------------------------------------------------------
package dsc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } dsc_state_e;

    // Result width: enough bits to hold 0..FRAME_LEN inclusive.
    function automatic int dsc_wxip1(input int data_width, input int num_inputs);
        return data_width * num_inputs + 1;
    endfunction

    // Frame length of a cascade of num_inputs SNGs of data_width bits each.
    function automatic int dsc_frame_len(input int data_width, input int num_inputs);
        return 1 << (data_width * num_inputs);
    endfunction

endpackage

// File: rtl/dsc_result_reg.sv
// -----------------------------------------------------------------------------
// dsc_result_reg
// One-entry valid/ready holding register. The entry accepts new data whenever
// it is empty or being drained in the same cycle, so a producer can keep a
// result flowing every cycle while the consumer is ready.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid, in_data   producer offers data (only loaded when in_ready)
//   in_ready            register is free this cycle
//   out_valid, out_data held result, stable while out_valid && !out_ready
//   out_ready           consumer takes the result
// -----------------------------------------------------------------------------
module dsc_result_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dsc_stream_decoder.sv
// -----------------------------------------------------------------------------
// dsc_stream_decoder
// Converts a framed serial unary bitstream back to binary by counting the ones
// in each frame of FRAME_LEN = 2^(DATA_WIDTH*NUM_INPUTS) bits. Completed
// counts leave through a one-entry valid/ready register; when that register is
// occupied at frame end the count is parked in HOLD and bs_ready drops.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_IDLE  | waiting for a bit with sof; bits without sof are dropped
// ST_ACCUM | counting bits of a frame; sof here restarts the frame
// ST_HOLD  | frame complete, output register busy, stream back-pressured
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   bs_valid, bs_data, bs_sof     incoming bitstream bit and frame start flag
//   bs_ready                      decoder accepts a bit this cycle
//   res_valid, res_ready, res_data  ones-count of the last completed frame
//   err_drop                      pulse: bit without sof discarded in IDLE
//   err_abort                     pulse: sof mid-frame, partial frame discarded
// -----------------------------------------------------------------------------
module dsc_stream_decoder
    import dsc_pkg::*;
#(
    parameter int DATA_WIDTH = 5,
    parameter int NUM_INPUTS = 2
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       bs_valid,
    input  logic                                       bs_data,
    input  logic                                       bs_sof,
    output logic                                       bs_ready,
    output logic                                       res_valid,
    input  logic                                       res_ready,
    output logic [dsc_wxip1(DATA_WIDTH, NUM_INPUTS)-1:0] res_data,
    output logic                                       err_drop,
    output logic                                       err_abort
);

    localparam int WXIP1     = dsc_wxip1(DATA_WIDTH, NUM_INPUTS);
    localparam int FRAME_LEN = dsc_frame_len(DATA_WIDTH, NUM_INPUTS);
    localparam logic [WXIP1-1:0] LAST_IDX = WXIP1'(FRAME_LEN - 1);

    dsc_state_e       state, state_nxt;
    logic [WXIP1-1:0] bit_cnt, bit_cnt_nxt;
    logic [WXIP1-1:0] ones_cnt, ones_cnt_nxt;
    logic [WXIP1-1:0] bit_val;
    logic [WXIP1-1:0] ones_final;
    logic [WXIP1-1:0] push_data;
    logic             push;
    logic             reg_free;
    logic             accept;
    logic             drop_nxt;
    logic             abort_nxt;

    assign bs_ready   = (state != ST_HOLD);
    assign accept     = bs_valid && bs_ready;
    assign bit_val    = WXIP1'(bs_data);
    assign ones_final = ones_cnt + bit_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            ones_cnt  <= '0;
            err_drop  <= 1'b0;
            err_abort <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            ones_cnt  <= ones_cnt_nxt;
            err_drop  <= drop_nxt;
            err_abort <= abort_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        ones_cnt_nxt = ones_cnt;
        push         = 1'b0;
        push_data    = ones_cnt;
        drop_nxt     = 1'b0;
        abort_nxt    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (bs_sof) begin
                        ones_cnt_nxt = bit_val;
                        bit_cnt_nxt  = WXIP1'(1);
                        state_nxt    = ST_ACCUM;
                    end else begin
                        drop_nxt = 1'b1;
                    end
                end
            end

            ST_ACCUM: begin
                if (accept) begin
                    if (bs_sof) begin
                        // Restart takes priority, even on what would be the last bit.
                        ones_cnt_nxt = bit_val;
                        bit_cnt_nxt  = WXIP1'(1);
                        abort_nxt    = 1'b1;
                    end else if (bit_cnt == LAST_IDX) begin
                        if (reg_free) begin
                            push         = 1'b1;
                            push_data    = ones_final;
                            ones_cnt_nxt = '0;
                            bit_cnt_nxt  = '0;
                            state_nxt    = ST_IDLE;
                        end else begin
                            ones_cnt_nxt = ones_final;
                            bit_cnt_nxt  = bit_cnt + WXIP1'(1);
                            state_nxt    = ST_HOLD;
                        end
                    end else begin
                        ones_cnt_nxt = ones_final;
                        bit_cnt_nxt  = bit_cnt + WXIP1'(1);
                    end
                end
            end

            ST_HOLD: begin
                if (reg_free) begin
                    push         = 1'b1;
                    push_data    = ones_cnt;
                    ones_cnt_nxt = '0;
                    bit_cnt_nxt  = '0;
                    state_nxt    = ST_IDLE;
                end
            end

            default: begin
                state_nxt    = ST_IDLE;
                ones_cnt_nxt = '0;
                bit_cnt_nxt  = '0;
            end
        endcase
    end

    dsc_result_reg #(
        .WIDTH (WXIP1)
    ) u_result_reg (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (push),
        .in_data   (push_data),
        .in_ready  (reg_free),
        .out_valid (res_valid),
        .out_ready (res_ready),
        .out_data  (res_data)
    );

endmodule

// File: tb/tb_dsc_stream_decoder.sv
module tb_dsc_stream_decoder;

    localparam int DW = 2;
    localparam int NI = 2;
    localparam int FL = 16;
    localparam int W  = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         bs_valid;
    logic         bs_data;
    logic         bs_sof;
    logic         bs_ready;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         err_drop;
    logic         err_abort;

    int errors = 0;
    int checks = 0;
    int drop_cnt = 0;
    int abort_cnt = 0;
    int got_q[$];
    bit rand_rr = 1'b0;

    dsc_stream_decoder #(
        .DATA_WIDTH (DW),
        .NUM_INPUTS (NI)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bs_valid  (bs_valid),
        .bs_data   (bs_data),
        .bs_sof    (bs_sof),
        .bs_ready  (bs_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .err_drop  (err_drop),
        .err_abort (err_abort)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge, so on the falling edge
    // res_valid && res_ready means a transfer happens on the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (res_valid && res_ready) got_q.push_back(int'(res_data));
            if (err_drop) drop_cnt++;
            if (err_abort) abort_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rr) res_ready = 1'($urandom_range(0, 1));
    endtask

    // Presents one bit (after optional idle gap) and holds it until accepted.
    task automatic send_bit(input logic d, input logic s, input int gap_max);
        int g;
        int guard;
        g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        repeat (g) begin
            bs_valid = 1'b0;
            step();
        end
        bs_valid = 1'b1;
        bs_data  = d;
        bs_sof   = s;
        guard    = 0;
        while (!bs_ready && guard < 300) begin
            step();
            guard++;
        end
        if (!bs_ready) begin
            errors++;
            $display("FAIL send_bit_timeout: bs_ready=%0b required 1", bs_ready);
        end
        step();
        bs_valid = 1'b0;
        bs_sof   = 1'b0;
    endtask

    task automatic send_frame(input logic [FL-1:0] bits, input int gap_max);
        for (int i = 0; i < FL; i++) send_bit(bits[i], (i == 0), gap_max);
    endtask

    task automatic wait_results(input int n);
        int guard;
        guard = 0;
        while (got_q.size() < n && guard < 300) begin
            step();
            guard++;
        end
    endtask

    function automatic logic [FL-1:0] frame_with_ones(input int k);
        logic [FL-1:0] v;
        v = '0;
        while ($countones(v) < k) v[$urandom_range(0, FL-1)] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1; bs_valid = 1'b0; bs_data = 1'b0; bs_sof = 1'b0; res_ready = 1'b1;
        repeat (2) step();
        checks++;
        if (bs_ready !== 1'b1) begin errors++; $display("FAIL reset_bs_ready_in_rst: got %0b exp 1", bs_ready); end
        rst = 1'b0;
        step();
        checks++;
        if (bs_ready !== 1'b1) begin errors++; $display("FAIL reset_bs_ready: got %0b exp 1", bs_ready); end
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %0b exp 0", res_valid); end
        checks++;
        if (res_data !== '0) begin errors++; $display("FAIL reset_res_data: got %0d exp 0", res_data); end
        checks++;
        if (err_drop !== 1'b0 || err_abort !== 1'b0) begin
            errors++; $display("FAIL reset_err: got drop=%0b abort=%0b exp 0 0", err_drop, err_abort);
        end
    endtask

    task automatic test_single_frame();
        logic [FL-1:0] v;
        v = frame_with_ones(5);
        res_ready = 1'b1;
        got_q.delete();
        send_frame(v, 0);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 5'd5) begin
            errors++; $display("FAIL single_latency: got valid=%0b data=%0d exp 1 5", res_valid, res_data);
        end
        step();
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL single_pulse: got valid=%0b exp 0", res_valid); end
        checks++;
        if (got_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d results exp 1", got_q.size()); end
        got_q.delete();
    endtask

    task automatic test_extremes();
        got_q.delete();
        res_ready = 1'b1;
        send_frame('1, 2);
        send_frame('0, 2);
        wait_results(2);
        checks++;
        if (got_q.size() != 2) begin
            errors++; $display("FAIL extremes_count: got %0d results exp 2", got_q.size());
        end else begin
            checks++;
            if (got_q[0] != FL) begin errors++; $display("FAIL all_ones: got %0d exp %0d", got_q[0], FL); end
            checks++;
            if (got_q[1] != 0) begin errors++; $display("FAIL all_zeros: got %0d exp 0", got_q[1]); end
        end
        got_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [FL-1:0] f1, f2;
        int bad;
        f1 = frame_with_ones(7);
        f2 = frame_with_ones(12);
        got_q.delete();
        res_ready = 1'b0;
        send_frame(f1, 0);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 5'd7) begin
            errors++; $display("FAIL b2b_first: got valid=%0b data=%0d exp 1 7", res_valid, res_data);
        end
        bad = 0;
        for (int i = 0; i < FL; i++) begin
            send_bit(f2[i], (i == 0), 0);
            if (res_valid !== 1'b1 || res_data !== 5'd7) bad++;
        end
        checks++;
        if (bs_ready !== 1'b0) begin errors++; $display("FAIL b2b_hold_ready: got %0b exp 0", bs_ready); end
        repeat (4) begin
            step();
            if (res_valid !== 1'b1 || res_data !== 5'd7 || bs_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL b2b_stable: got %0d unstable cycles exp 0", bad); end
        res_ready = 1'b1;
        step();
        checks++;
        if (bs_ready !== 1'b1 || res_data !== 5'd12) begin
            errors++; $display("FAIL b2b_release: got ready=%0b data=%0d exp 1 12", bs_ready, res_data);
        end
        step();
        checks++;
        if (got_q.size() != 2) begin
            errors++; $display("FAIL b2b_count: got %0d results exp 2", got_q.size());
        end else if (got_q[0] != 7 || got_q[1] != 12) begin
            errors++; $display("FAIL b2b_order: got %0d,%0d exp 7,12", got_q[0], got_q[1]);
        end
        got_q.delete();
    endtask

    task automatic test_drop();
        logic [FL-1:0] v;
        got_q.delete();
        res_ready = 1'b1;
        drop_cnt = 0;
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 1);
        repeat (3) step();
        checks++;
        if (drop_cnt != 3) begin errors++; $display("FAIL drop_pulses: got %0d exp 3", drop_cnt); end
        checks++;
        if (got_q.size() != 0) begin errors++; $display("FAIL drop_no_result: got %0d results exp 0", got_q.size()); end
        v = 16'($urandom);
        send_frame(v, 1);
        wait_results(1);
        checks++;
        if (got_q.size() != 1 || got_q[0] != $countones(v)) begin
            errors++; $display("FAIL drop_next_frame: got n=%0d val=%0d exp %0d", got_q.size(),
                               (got_q.size() > 0) ? got_q[0] : -1, $countones(v));
        end
        checks++;
        if (drop_cnt != 3) begin errors++; $display("FAIL drop_spurious: got %0d exp 3", drop_cnt); end
        got_q.delete();
    endtask

    task automatic test_abort();
        logic [FL-1:0] pre, v;
        pre = '1;
        v = 16'($urandom);
        got_q.delete();
        res_ready = 1'b1;
        abort_cnt = 0;
        for (int i = 0; i < 8; i++) send_bit(pre[i], (i == 0), 0);
        send_frame(v, 0);
        wait_results(1);
        repeat (2) step();
        checks++;
        if (abort_cnt != 1) begin errors++; $display("FAIL abort_pulses: got %0d exp 1", abort_cnt); end
        checks++;
        if (got_q.size() != 1 || got_q[0] != $countones(v)) begin
            errors++; $display("FAIL abort_result: got n=%0d val=%0d exp %0d", got_q.size(),
                               (got_q.size() > 0) ? got_q[0] : -1, $countones(v));
        end
        got_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [FL-1:0] v;
        res_ready = 1'b1;
        v = 16'($urandom);
        for (int i = 0; i < 10; i++) send_bit(v[i], (i == 0), 0);
        rst = 1'b1;
        #1;
        checks++;
        if (bs_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== '0 || err_drop !== 1'b0 || err_abort !== 1'b0) begin
            errors++; $display("FAIL rst_mid_frame: got ready=%0b valid=%0b data=%0d drop=%0b abort=%0b exp 1 0 0 0 0",
                               bs_ready, res_valid, res_data, err_drop, err_abort);
        end
        step();
        rst = 1'b0;
        step();
        res_ready = 1'b0;
        send_frame(frame_with_ones(9), 0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, (i == 0), 0);
        rst = 1'b1;
        #1;
        checks++;
        if (bs_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== '0) begin
            errors++; $display("FAIL rst_pending: got ready=%0b valid=%0b data=%0d exp 1 0 0", bs_ready, res_valid, res_data);
        end
        step();
        rst = 1'b0;
        got_q.delete();
        abort_cnt = 0;
        drop_cnt = 0;
        res_ready = 1'b1;
        step();
        v = 16'($urandom);
        send_frame(v, 0);
        wait_results(1);
        checks++;
        if (got_q.size() != 1 || got_q[0] != $countones(v) || abort_cnt != 0 || drop_cnt != 0) begin
            errors++; $display("FAIL rst_next_frame: got n=%0d val=%0d aborts=%0d drops=%0d exp 1 %0d 0 0",
                               got_q.size(), (got_q.size() > 0) ? got_q[0] : -1, abort_cnt, drop_cnt, $countones(v));
        end
        got_q.delete();
    endtask

    task automatic test_random();
        int exp_q[$];
        logic [FL-1:0] v;
        got_q.delete();
        rand_rr = 1'b1;
        for (int f = 0; f < 8; f++) begin
            v = 16'($urandom);
            exp_q.push_back($countones(v));
            send_frame(v, (f % 2 == 0) ? 0 : 3);
        end
        rand_rr = 1'b0;
        res_ready = 1'b1;
        wait_results(exp_q.size());
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL random_count: got %0d results exp %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] != exp_q[i]) begin
                    errors++; $display("FAIL random_frame%0d: got %0d exp %0d", i, got_q[i], exp_q[i]);
                end
            end
        end
        got_q.delete();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_extremes();
        test_back_to_back();
        test_drop();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
